mult_div_unit: RTL and testbench

Sequential multiply/divide unit owning the HI/LO register pair, the multi-cycle successor to the single-cycle combinational MULT/DIV path inside the ALU. It accepts one MULT, MULTU, DIV, DIVU, MTHI or MTLO request at a time from the execute stage and computes products and quotients iteratively, one bit per cycle. While an operation is in flight it raises a busy flag so the pipeline controller can stall MFHI/MFLO. HI/LO are visible continuously to the execute-stage result mux.

---
 rtl/mult_div_unit_pkg.sv | 25 ++
 rtl/mult_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared SPECIAL function codes and decode helpers for the multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [5:0] SpecialMthi  = 6'h11;
  localparam logic [5:0] SpecialMtlo  = 6'h13;
  localparam logic [5:0] SpecialMult  = 6'h18;
  localparam logic [5:0] SpecialMultu = 6'h19;
  localparam logic [5:0] SpecialDiv   = 6'h1a;
  localparam logic [5:0] SpecialDivu  = 6'h1b;

  // Codes that launch a multi-cycle operation.
  function automatic logic is_mul_div(input logic [5:0] op);
    return (op == SpecialMult) || (op == SpecialMultu) ||
           (op == SpecialDiv)  || (op == SpecialDivu);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == SpecialMult) || (op == SpecialDiv);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == SpecialDiv) || (op == SpecialDivu);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; one result bit per cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             w_start_1,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  input  logic             w_flush_1,
  output logic             w_busy_1,
  output logic             w_done_1,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate2(input logic [2*WIDTH-1:0] v);
    return -v;
  endfunction

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   src_q, src_d;     // raw dividend, returned on divide by zero
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand preparation for a newly accepted request.
  logic             start_md, l_sign1, l_sign2, l_div;
  logic [WIDTH-1:0] l_mag1, l_mag2;

  assign start_md = w_start_1 && is_mul_div(w_op_code_6);
  assign l_div    = is_div_op(w_op_code_6);
  assign l_sign1  = is_signed_op(w_op_code_6) && w_input1_x[WIDTH-1];
  assign l_sign2  = is_signed_op(w_op_code_6) && w_input2_x[WIDTH-1];
  assign l_mag1   = magnitude(w_input1_x, l_sign1);
  assign l_mag2   = magnitude(w_input2_x, l_sign2);

  // One iteration of shift-add or restoring shift-subtract.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] iter_acc, prod_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (is_div_q) begin
      iter_acc = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
    end else begin
      iter_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod_fix = neg_lo_q ? negate2(acc_q) : acc_q;
  end

  // Next-state, datapath and output register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    src_d    = src_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!w_flush_1 && w_start_1) begin
          if (start_md) begin
            state_d = StRun;
            busy_d  = 1'b1;
          end else if (w_op_code_6 == SpecialMthi) begin
            hi_d = w_input1_x;
          end else if (w_op_code_6 == SpecialMtlo) begin
            lo_d = w_input1_x;
          end
        end
      end
      StRun: begin
        if (w_flush_1) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = iter_acc;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StFix;
            cnt_d   = '0;
          end
        end
      end
      StFix: begin
        if (w_flush_1) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (opnd_q == '0) begin
            hi_d = src_q;
            lo_d = '1;
          end else begin
            hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
          // A request waiting here starts immediately for full throughput.
          if (start_md) begin
            state_d = StRun;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Operand latch shared by IDLE and FIX acceptance.
    if (state_d == StRun && state_q != StRun) begin
      cnt_d    = '0;
      is_div_d = l_div;
      neg_lo_d = l_sign1 ^ l_sign2;
      neg_hi_d = l_sign1;
      src_d    = w_input1_x;
      acc_d    = l_div ? {{WIDTH{1'b0}}, l_mag1} : {{WIDTH{1'b0}}, l_mag2};
      opnd_d   = l_div ? l_mag2 : l_mag1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      src_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      src_q    <= src_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign w_busy_1 = busy_q;
  assign w_done_1 = done_q;
  assign w_hi_x   = hi_q;
  assign w_lo_x   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        w_start_1 = 1'b0;
  logic [5:0]  w_op_code_6 = 6'h0;
  logic [31:0] w_input1_x = '0;
  logic [31:0] w_input2_x = '0;
  logic        w_flush_1 = 1'b0;
  logic        w_busy_1, w_done_1;
  logic [31:0] w_hi_x, w_lo_x;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .w_start_1   (w_start_1),
    .w_op_code_6 (w_op_code_6),
    .w_input1_x  (w_input1_x),
    .w_input2_x  (w_input2_x),
    .w_flush_1   (w_flush_1),
    .w_busy_1    (w_busy_1),
    .w_done_1    (w_done_1),
    .w_hi_x      (w_hi_x),
    .w_lo_x      (w_lo_x)
  );

  always #5 clock = ~clock;

  // Reference: results from plain 64-bit and native signed arithmetic.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    hi = '0;
    lo = '0;
    sa = $signed(a);
    sb = $signed(b);
    if (op == SpecialMult) begin
      sp = longint'(sa) * longint'(sb);
      up = sp;
      hi = up[63:32];
      lo = up[31:0];
    end else if (op == SpecialMultu) begin
      up = {32'h0, a} * {32'h0, b};
      hi = up[63:32];
      lo = up[31:0];
    end else if (b == 32'h0) begin
      hi = a;
      lo = 32'hffff_ffff;
    end else if (op == SpecialDiv) begin
      if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
        hi = 32'h0;
        lo = 32'h8000_0000;
      end else begin
        lo = sa / sb;
        hi = sa % sb;
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request for exactly one edge; returns just after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    w_start_1   = 1'b1;
    w_op_code_6 = op;
    w_input1_x  = a;
    w_input2_x  = b;
    step();
    w_start_1 = 1'b0;
  endtask

  // Bounded wait for done; reports edges elapsed and busy samples seen.
  task automatic wait_done(output int edges, output int bcnt, output bit tmo);
    edges = 0;
    bcnt  = w_busy_1 ? 1 : 0;
    while (w_done_1 !== 1'b1 && edges < 100) begin
      step();
      edges++;
      if (w_busy_1 === 1'b1) bcnt++;
    end
    tmo = (w_done_1 !== 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_cmp++; if (w_busy_1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", w_busy_1); end
    n_cmp++; if (w_done_1 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", w_done_1); end
    n_cmp++; if (w_hi_x !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", w_hi_x); end
    n_cmp++; if (w_lo_x !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", w_lo_x); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [5:0]  ops[8];
    logic [31:0] as[8], bs[8], ehi[8], elo[8];
    int e, bc;
    bit tmo;
    ops[0] = SpecialMultu; as[0] = 32'hffffffff; bs[0] = 32'hffffffff; ehi[0] = 32'hfffffffe; elo[0] = 32'h1;
    ops[1] = SpecialMult;  as[1] = 32'hfffffffd; bs[1] = 32'h5;        ehi[1] = 32'hffffffff; elo[1] = 32'hfffffff1;
    ops[2] = SpecialMult;  as[2] = 32'h80000000; bs[2] = 32'h80000000; ehi[2] = 32'h40000000; elo[2] = 32'h0;
    ops[3] = SpecialDiv;   as[3] = 32'hfffffff9; bs[3] = 32'h2;        ehi[3] = 32'hffffffff; elo[3] = 32'hfffffffd;
    ops[4] = SpecialDivu;  as[4] = 32'h7;        bs[4] = 32'h2;        ehi[4] = 32'h1;        elo[4] = 32'h3;
    ops[5] = SpecialDiv;   as[5] = 32'h7;        bs[5] = 32'hfffffffe; ehi[5] = 32'h1;        elo[5] = 32'hfffffffd;
    ops[6] = SpecialDiv;   as[6] = 32'd100;      bs[6] = 32'h0;        ehi[6] = 32'd100;      elo[6] = 32'hffffffff;
    ops[7] = SpecialDiv;   as[7] = 32'h80000000; bs[7] = 32'hffffffff; ehi[7] = 32'h0;        elo[7] = 32'h80000000;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(e, bc, tmo);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL dir%0d_timeout: done never seen", i); end
      n_cmp++; if (w_hi_x !== ehi[i]) begin n_bad++; $display("FAIL dir%0d_hi: got %h want %h", i, w_hi_x, ehi[i]); end
      n_cmp++; if (w_lo_x !== elo[i]) begin n_bad++; $display("FAIL dir%0d_lo: got %h want %h", i, w_lo_x, elo[i]); end
      n_cmp++; if (e !== 33) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want 33", i, e); end
      n_cmp++; if (bc !== 33) begin n_bad++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bc); end
      step();
      n_cmp++; if (w_done_1 !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_width: got %b want 0", i, w_done_1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h1, l1, h2, l2;
    int e, bc;
    bit tmo;
    model(SpecialMult, 32'hdeadbeef, 32'h01234567, h1, l1);
    model(SpecialDivu, 32'hcafef00d, 32'h00000123, h2, l2);
    issue(SpecialMult, 32'hdeadbeef, 32'h01234567);
    repeat (32) step();
    // Present the next request during the write-back cycle.
    w_start_1 = 1'b1; w_op_code_6 = SpecialDivu; w_input1_x = 32'hcafef00d; w_input2_x = 32'h123;
    step();
    w_start_1 = 1'b0;
    n_cmp++; if (w_done_1 !== 1'b1) begin n_bad++; $display("FAIL b2b_done1: got %b want 1", w_done_1); end
    n_cmp++; if (w_hi_x !== h1) begin n_bad++; $display("FAIL b2b_hi1: got %h want %h", w_hi_x, h1); end
    n_cmp++; if (w_lo_x !== l1) begin n_bad++; $display("FAIL b2b_lo1: got %h want %h", w_lo_x, l1); end
    n_cmp++; if (w_busy_1 !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", w_busy_1); end
    step();
    wait_done(e, bc, tmo);
    n_cmp++; if (tmo || e + 1 !== 33) begin n_bad++; $display("FAIL b2b_latency2: got %0d want 33", e + 1); end
    n_cmp++; if (w_hi_x !== h2) begin n_bad++; $display("FAIL b2b_hi2: got %h want %h", w_hi_x, h2); end
    n_cmp++; if (w_lo_x !== l2) begin n_bad++; $display("FAIL b2b_lo2: got %h want %h", w_lo_x, l2); end
    step();
  endtask

  task automatic test_random();
    logic [5:0]  opset[4];
    logic [31:0] specials[6];
    logic [31:0] a, b, eh, el;
    logic [5:0]  op;
    int e, bc;
    bit tmo;
    opset[0] = SpecialMult; opset[1] = SpecialMultu; opset[2] = SpecialDiv; opset[3] = SpecialDivu;
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hffffffff;
    specials[3] = 32'h80000000; specials[4] = 32'h7fffffff; specials[5] = 32'h3;
    for (int i = 0; i < 30; i++) begin
      op = opset[$urandom_range(3, 0)];
      a  = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
      b  = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)]
                                       : ($urandom >> $urandom_range(31, 0));
      model(op, a, b, eh, el);
      issue(op, a, b);
      wait_done(e, bc, tmo);
      n_cmp++; if (tmo || w_hi_x !== eh) begin
        n_bad++; $display("FAIL rnd%0d_hi op=%h a=%h b=%h: got %h want %h", i, op, a, b, w_hi_x, eh);
      end
      n_cmp++; if (w_lo_x !== el) begin
        n_bad++; $display("FAIL rnd%0d_lo op=%h a=%h b=%h: got %h want %h", i, op, a, b, w_lo_x, el);
      end
      if ($urandom_range(1, 0) == 1) step();
    end
    step();
  endtask

  task automatic test_busy_ignore();
    int e, bc, dcnt, bcnt;
    bit tmo;
    issue(SpecialMultu, 32'd3, 32'd4);
    repeat (4) step();
    issue(SpecialDivu, 32'd100, 32'd3);
    issue(SpecialMthi, 32'h0bad0bad, 32'h0);
    wait_done(e, bc, tmo);
    n_cmp++; if (tmo || e + 6 !== 33) begin n_bad++; $display("FAIL busy_ign_latency: got %0d want 33", e + 6); end
    n_cmp++; if (w_hi_x !== 32'h0) begin n_bad++; $display("FAIL busy_ign_hi: got %h want 0", w_hi_x); end
    n_cmp++; if (w_lo_x !== 32'd12) begin n_bad++; $display("FAIL busy_ign_lo: got %h want c", w_lo_x); end
    dcnt = 0; bcnt = 0;
    repeat (40) begin step(); if (w_done_1) dcnt++; if (w_busy_1) bcnt++; end
    n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL busy_ign_extra_done: got %0d want 0", dcnt); end
    n_cmp++; if (bcnt !== 0) begin n_bad++; $display("FAIL busy_ign_extra_busy: got %0d want 0", bcnt); end
    // Unrecognised code is ignored entirely.
    issue(6'h20, 32'h55555555, 32'h2);
    n_cmp++; if (w_busy_1 !== 1'b0) begin n_bad++; $display("FAIL bad_op_busy: got %b want 0", w_busy_1); end
    n_cmp++; if (w_lo_x !== 32'd12) begin n_bad++; $display("FAIL bad_op_lo: got %h want c", w_lo_x); end
  endtask

  task automatic test_mthi_mtlo();
    int bcnt, dcnt;
    bcnt = 0; dcnt = 0;
    issue(SpecialMthi, 32'h1234, 32'hffff);
    if (w_busy_1) bcnt++;
    if (w_done_1) dcnt++;
    n_cmp++; if (w_hi_x !== 32'h1234) begin n_bad++; $display("FAIL mthi_hi: got %h want 1234", w_hi_x); end
    issue(SpecialMtlo, 32'h5678, 32'hffff);
    if (w_busy_1) bcnt++;
    if (w_done_1) dcnt++;
    step();
    if (w_busy_1) bcnt++;
    n_cmp++; if (w_lo_x !== 32'h5678) begin n_bad++; $display("FAIL mtlo_lo: got %h want 5678", w_lo_x); end
    n_cmp++; if (w_hi_x !== 32'h1234) begin n_bad++; $display("FAIL mtlo_hi_kept: got %h want 1234", w_hi_x); end
    n_cmp++; if (bcnt !== 0) begin n_bad++; $display("FAIL mthi_mtlo_busy: got %0d want 0", bcnt); end
    n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL mthi_mtlo_done: got %0d want 0", dcnt); end
  endtask

  task automatic test_flush();
    int dcnt;
    issue(SpecialDiv, 32'd100, 32'd7);
    repeat (9) step();
    w_flush_1 = 1'b1;
    step();
    w_flush_1 = 1'b0;
    n_cmp++; if (w_busy_1 !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", w_busy_1); end
    dcnt = 0;
    repeat (40) begin step(); if (w_done_1) dcnt++; end
    n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL flush_done: got %0d want 0", dcnt); end
    n_cmp++; if (w_hi_x !== 32'h1234) begin n_bad++; $display("FAIL flush_hi: got %h want 1234", w_hi_x); end
    n_cmp++; if (w_lo_x !== 32'h5678) begin n_bad++; $display("FAIL flush_lo: got %h want 5678", w_lo_x); end
    // Flush and start together while idle: the request is dropped.
    w_flush_1 = 1'b1;
    issue(SpecialMultu, 32'd9, 32'd9);
    w_flush_1 = 1'b0;
    n_cmp++; if (w_busy_1 !== 1'b0) begin n_bad++; $display("FAIL flush_start_busy: got %b want 0", w_busy_1); end
    dcnt = 0;
    repeat (40) begin step(); if (w_done_1) dcnt++; end
    n_cmp++; if (dcnt !== 0 || w_lo_x !== 32'h5678) begin
      n_bad++; $display("FAIL flush_start_drop: done=%0d lo=%h want 0/5678", dcnt, w_lo_x);
    end
  endtask

  task automatic test_reset_mid();
    int e, bc;
    bit tmo;
    issue(SpecialMult, 32'h12345678, 32'h9abcdef0);
    repeat (5) step();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (w_busy_1 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", w_busy_1); end
    n_cmp++; if (w_done_1 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done: got %b want 0", w_done_1); end
    n_cmp++; if (w_hi_x !== 32'h0 || w_lo_x !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", w_hi_x, w_lo_x);
    end
    step();
    reset_n = 1'b1;
    issue(SpecialMultu, 32'd2, 32'd3);
    wait_done(e, bc, tmo);
    n_cmp++; if (tmo || w_lo_x !== 32'd6) begin n_bad++; $display("FAIL rst_mid_after_lo: got %h want 6", w_lo_x); end
    n_cmp++; if (w_hi_x !== 32'h0) begin n_bad++; $display("FAIL rst_mid_after_hi: got %h want 0", w_hi_x); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_busy_ignore();
    test_mthi_mtlo();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
